// File: rtl/rv32i_opcodes.sv
// Shared RV32I opcode definitions.
//   rv32i_opcode_t : the seven-bit major opcode field, ir[6:0]
//   RV32I_NOP      : canonical NOP encoding (addi x0, x0, 0)
package rv32i_opcodes;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rv32i_opcode_t;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus (req/ack handshake).
//   req   : read request, held until ack
//   addr  : read address, stable while req=1
//   rdata : read data, valid when ack=1
//   ack   : request complete; only meaningful while req=1
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] rdata;
    logic             ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit for the multicycle RV32I core: owns the fetch PC and the
// instruction register, issues one memory read per fetch_start and handles
// JAL/JALR redirects, squashing any access that is in flight.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   fetch_start         : start one fetch (only honoured while idle)
//   jumping/jump_target : redirect strobe and target address
//   imem                : instruction-memory bus (master side)
//   ir, opcode          : current instruction and its opcode field
//   pc, pc_plus_4       : address of ir and its sequential successor
//   fetch_done          : one-cycle pulse when ir/pc were updated
//   misaligned          : sticky, a redirect target had bit 1 set
// Only WIDTH=32 is supported.
module instr_fetch_unit
    import rv32i_opcodes::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_start,
    input  logic                jumping,
    input  logic [WIDTH-1:0]    jump_target,
    instr_fetch_unit_if.master  imem,
    output logic [WIDTH-1:0]    ir,
    output rv32i_opcode_t       opcode,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus_4,
    output logic                fetch_done,
    output logic                misaligned
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } fetch_state_t;

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             squash_q, squash_d;
    logic             fetch_done_q, fetch_done_d;
    logic             misaligned_q, misaligned_d;

    logic [WIDTH-1:0] target;
    logic             unused_jump_bit0;

    // JALR clears bit 0 of the computed target; bit 1 is kept so that a
    // misaligned target is still visible in fetch_pc.
    assign target           = {jump_target[WIDTH-1:1], 1'b0};
    assign unused_jump_bit0 = jump_target[0];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pending_d    = pending_q;
        squash_d     = squash_q;
        fetch_done_d = 1'b0;
        misaligned_d = misaligned_q | (jumping & jump_target[1]);

        unique case (state_q)
            IDLE: begin
                if (jumping) begin
                    fetch_pc_d = target;
                end
                // misaligned_d is used so a misaligned redirect arriving with
                // fetch_start never issues a fetch at the bad address.
                if (fetch_start && !misaligned_d) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (jumping && imem.ack) begin
                    // Data returned in the redirect cycle belongs to the old
                    // path: drop it and re-issue straight at the new target.
                    fetch_pc_d = target;
                    squash_d   = 1'b0;
                    if (misaligned_d) begin
                        state_d = IDLE;
                    end
                end else if (jumping) begin
                    // Access still in flight: remember the target and discard
                    // whatever comes back for the old address.
                    pending_d = target;
                    squash_d  = 1'b1;
                end else if (imem.ack && squash_q) begin
                    fetch_pc_d = pending_q;
                    squash_d   = 1'b0;
                    if (misaligned_q) begin
                        state_d = IDLE;
                    end
                end else if (imem.ack) begin
                    ir_d         = imem.rdata;
                    pc_d         = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + WIDTH'(4);
                    fetch_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            ir_q         <= RV32I_NOP;
            pending_q    <= RESET_PC;
            squash_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pending_q    <= pending_d;
            squash_q     <= squash_d;
            fetch_done_q <= fetch_done_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem.req   = (state_q == WAIT_ACK);
    assign imem.addr  = fetch_pc_q;
    assign ir         = ir_q;
    assign opcode     = rv32i_opcode_t'(ir_q[6:0]);
    assign pc         = pc_q;
    assign pc_plus_4  = pc_q + WIDTH'(4);
    assign fetch_done = fetch_done_q;
    assign misaligned = misaligned_q;

endmodule
